uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Buffered UART transmitter that serialises the RLE byte stream produced by the row compressor onto the serial line toward the host. Accepted bytes go into a small FIFO, which absorbs compressor bursts. Bytes are sent as 8N1 frames, LSB first. There is an integer clocks-per-bit divider, and consecutive frames are sent with no idle gap.

## Interface
- `ClksPerBit`, 217 — clock cycles per UART bit (25 MHz / 115200); integer ≥ 2.
- `FifoDepth`, 16 — byte FIFO depth; power of two, ≥ 2.

- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `i_data`  in  8  byte from compressor (`o_frame`).
- `i_valid`  in  1  `i_data` valid this cycle (compressor `o_ready`).
- `o_full`  out  1  FIFO holds `FifoDepth` bytes; a push this cycle is rejected.
- `o_level`  out  $clog2(FifoDepth)+1  bytes currently buffered.
- `o_overflow`  out  1  sticky: a push was attempted while `o_full`.
- `o_busy`  out  1  serialiser not in IDLE.
- `o_tx`  out  1  serial line; idle high.

## Operation
- **Push:** on an edge with `i_valid`=1 and `o_full`=0, write `i_data` at the write pointer.
  - Push with `o_full`=1: the byte is dropped and `o_overflow` is set until reset.
  - `o_full` is decided from the registered count before any same-cycle pop, so a push while full is rejected even if a pop occurs on that edge.
- **Pop:** performed by the FSM, defined below.
  - Push and pop on the same edge leave `o_level` unchanged.
- **Pointers:** $clog2(FifoDepth) bits each, wrap naturally. `o_level` counts 0..`FifoDepth`.
- **FSM states:** IDLE, START, DATA, STOP. A bit counter (0..`ClksPerBit`-1) and a data index (0..7) are maintained.
  - **IDLE:** `o_tx`=1. If `o_level`≠0, pop into the shift register, clear the bit counter, go to START.
  - **START:** `o_tx`=0 for `ClksPerBit` cycles, then go to DATA with index 0.
  - **DATA:** `o_tx`=shift[0] for `ClksPerBit` cycles, then shift right. After index 7, go to STOP.
  - **STOP:** `o_tx`=1 for `ClksPerBit` cycles. At the end: if `o_level`≠0, pop and go directly to START; otherwise go to IDLE.
- **Output registering:** `o_tx` is a register with no combinational path from the FIFO.
- **`o_busy`:** equals (state≠IDLE).
- **Reset:**
  - Asserting `RST` at any time, including mid-frame, forces IDLE immediately and asynchronously. The frame is truncated.
  - The FIFO empties: pointers and count go to 0, and buffered bytes are discarded.
  - Output values under reset: `o_tx`=1, `o_busy`=0, `o_full`=0, `o_level`=0, `o_overflow`=0.

## Timing
- **Write latency:** a byte accepted on edge E into an empty FIFO with the FSM in IDLE is popped on edge E+1. `o_tx` goes low after E+1.
- **Frame length:** exactly 10·`ClksPerBit` cycles. Each bit lasts exactly `ClksPerBit` cycles.
- **Back-to-back frames:** when the FIFO is non-empty at the end of STOP, the next start bit begins on the cycle after the last stop-bit cycle. Frame period is 10·`ClksPerBit`.
- **Flag timing:** `o_level` and `o_full` update on the edge after a push or pop. `o_overflow` rises on the edge after the rejected push.
- **Throughput bound:** sustained input must average ≤ 1 byte per 10·`ClksPerBit` cycles; excess is reported via `o_overflow`.

## Test plan
Use `ClksPerBit`=4 and `FifoDepth`=4 throughout.
- **Single byte:** push 0xA5 once.
  - `o_tx` pattern: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - `o_busy` high for 40 cycles; `o_level` goes 1 → 0 on the next edge.
- **Back-to-back:** push 0x00 and 0xFF on consecutive cycles.
  - The second start bit directly follows the first stop bit.
  - `o_busy` is continuous for 80 cycles, then returns to IDLE.
- **Overflow:** push 6 bytes 0x10..0x15 on consecutive edges.
  - `o_level` sequence: 1, 1, 2, 3, 4; `o_full`=1.
  - 0x15 is rejected and `o_overflow`=1.
  - Bytes 0x10..0x14 are serialised in order.
- **Full with simultaneous pop:** fill the FIFO, then push on the edge where STOP ends and pops.
  - The push is rejected and `o_overflow` is set.
  - `o_level` goes to 3.
- **Reset mid-frame:** with 2 bytes buffered, assert `RST` during DATA index 3.
  - `o_tx`=1 immediately; `o_busy`, `o_level`, and `o_overflow` are all 0.
  - After release with no pushes, the line stays idle-high.
- **Pointer wrap:** push 9 bytes paced one per 40 cycles.
  - All 9 are serialised correctly across the pointer wrap.
  - `o_overflow` stays 0.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: byte FIFO feeding an 8N1 serialiser (LSB first) with an
// integer clocks-per-bit divider; queued bytes go out back-to-back.
module uart_frame_tx #(
  parameter int ClksPerBit = 217,
  parameter int FifoDepth  = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [7:0]                 i_data,
  input  logic                       i_valid,
  output logic                       o_full,
  output logic [$clog2(FifoDepth):0] o_level,
  output logic                       o_overflow,
  output logic                       o_busy,
  output logic                       o_tx
);

  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(ClksPerBit);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FifoDepth);
  localparam logic [CW-1:0] LAST_CNT   = CW'(ClksPerBit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FifoDepth];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          overflow_reg;

  state_t        state_reg, state_next;
  logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg;
  logic          tx_reg, tx_next;

  logic push;
  logic pop;
  logic shift_en;
  logic bit_end;
  logic fifo_nonempty;

  // Full is judged on the registered count, so a same-edge pop cannot make room.
  assign o_full        = (count_reg == FULL_LEVEL);
  assign push          = i_valid && !o_full;
  assign fifo_nonempty = (count_reg != '0);
  assign bit_end       = (bit_cnt_reg == LAST_CNT);

  // Storage and the pop-side read register carry no reset so they map to RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data;
    end
    if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + LW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - LW'(1);
      end
      if (i_valid && o_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      idx_reg     <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      idx_reg     <= idx_next;
      tx_reg      <= tx_next;
    end
  end

  // tx_next is the line level for the cycle that follows this edge.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    idx_next     = idx_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    shift_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (fifo_nonempty) begin
          pop          = 1'b1;
          state_next   = START;
          bit_cnt_next = '0;
          tx_next      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
          idx_next     = '0;
          tx_next      = shift_reg[0];
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          shift_en     = 1'b1;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            idx_next = idx_reg + 3'd1;
            tx_next  = shift_reg[1];
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          if (fifo_nonempty) begin
            pop        = 1'b1;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign o_level    = count_reg;
  assign o_overflow = overflow_reg;
  assign o_busy     = (state_reg != IDLE);
  assign o_tx       = tx_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with 4 clocks per bit and a 4-deep FIFO.
module tb_uart_frame_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_full;
  logic [2:0] o_level;
  logic       o_overflow;
  logic       o_busy;
  logic       o_tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_tx #(.ClksPerBit(4), .FifoDepth(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_full     (o_full),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_tx       (o_tx)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge showing frame cycle first_c; returns at cycle 39.
  task automatic check_frame(input logic [7:0] d, input int first_c);
    logic exp_bit;
    for (int c = first_c; c < 40; c++) begin
      if (c != first_c) @(negedge CLK);
      if (c < 4)        exp_bit = 1'b0;
      else if (c >= 36) exp_bit = 1'b1;
      else              exp_bit = d[3'((c - 4) / 4)];
      check($sformatf("tx_%02h_c%0d", d, c), 32'(o_tx), 32'(exp_bit));
      check($sformatf("busy_%02h_c%0d", d, c), 32'(o_busy), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 32'(o_tx), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_level"}, 32'(o_level), 32'd0);
  endtask

  logic [7:0] wrap_bytes [9] = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h7E, 8'hE7, 8'h96};
  logic       any_low;

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_tx", 32'(o_tx), 32'd1);

    // Single byte 0xA5
    i_data = 8'hA5; i_valid = 1'b1;
    @(negedge CLK); i_valid = 1'b0;
    check("single_level1", 32'(o_level), 32'd1);
    check("single_tx_still_idle", 32'(o_tx), 32'd1);
    check("single_busy_still_0", 32'(o_busy), 32'd0);
    @(negedge CLK);
    check("single_level0", 32'(o_level), 32'd0);
    check_frame(8'hA5, 0);
    @(negedge CLK);
    check_idle("single_end");

    // Back-to-back 0x00, 0xFF
    i_data = 8'h00; i_valid = 1'b1;
    @(negedge CLK); i_data = 8'hFF;
    @(negedge CLK); i_valid = 1'b0;
    check("b2b_level1", 32'(o_level), 32'd1);
    check_frame(8'h00, 0);
    @(negedge CLK);
    check("b2b_level0", 32'(o_level), 32'd0);
    check_frame(8'hFF, 0);
    @(negedge CLK);
    check_idle("b2b_end");

    // Overflow: 0x10..0x15 on consecutive edges
    i_data = 8'h10; i_valid = 1'b1;
    @(negedge CLK); check("ovf_level_e1", 32'(o_level), 32'd1); i_data = 8'h11;
    @(negedge CLK); check("ovf_level_e2", 32'(o_level), 32'd1); i_data = 8'h12;
    @(negedge CLK); check("ovf_level_e3", 32'(o_level), 32'd2); i_data = 8'h13;
    @(negedge CLK); check("ovf_level_e4", 32'(o_level), 32'd3); i_data = 8'h14;
    @(negedge CLK); check("ovf_level_e5", 32'(o_level), 32'd4);
    check("ovf_full_e5", 32'(o_full), 32'd1);
    check("ovf_flag_e5", 32'(o_overflow), 32'd0);
    i_data = 8'h15;
    @(negedge CLK); i_valid = 1'b0;
    check("ovf_flag_e6", 32'(o_overflow), 32'd1);
    check("ovf_level_e6", 32'(o_level), 32'd4);
    check_frame(8'h10, 4);
    for (int b = 1; b < 5; b++) begin
      @(negedge CLK);
      check_frame(8'h10 + 8'(b), 0);
    end
    @(negedge CLK);
    check_idle("ovf_end");
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Full with simultaneous pop at STOP end
    do_reset();
    check("fp_ovf_cleared", 32'(o_overflow), 32'd0);
    i_data = 8'h20; i_valid = 1'b1;
    for (int b = 1; b < 5; b++) begin
      @(negedge CLK); i_data = 8'h20 + 8'(b);
    end
    @(negedge CLK); i_valid = 1'b0;
    check("fp_level4", 32'(o_level), 32'd4);
    check("fp_full", 32'(o_full), 32'd1);
    check_frame(8'h20, 3);
    i_data = 8'h99; i_valid = 1'b1;
    @(negedge CLK); i_valid = 1'b0;
    check("fp_level3", 32'(o_level), 32'd3);
    check("fp_ovf", 32'(o_overflow), 32'd1);
    check("fp_full_after", 32'(o_full), 32'd0);
    check_frame(8'h21, 0);
    for (int b = 2; b < 5; b++) begin
      @(negedge CLK);
      check_frame(8'h20 + 8'(b), 0);
    end
    @(negedge CLK);
    check_idle("fp_end");

    // Reset mid-frame during DATA index 3, overflow still set from above
    i_data = 8'h30; i_valid = 1'b1;
    @(negedge CLK); i_data = 8'h31;
    @(negedge CLK); i_data = 8'h32;
    @(negedge CLK); i_valid = 1'b0;
    check("rmf_level2", 32'(o_level), 32'd2);
    repeat (16) @(negedge CLK);
    check("rmf_tx_bit3", 32'(o_tx), 32'd0);
    check("rmf_busy_pre", 32'(o_busy), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rmf_tx_async", 32'(o_tx), 32'd1);
    check("rmf_busy_async", 32'(o_busy), 32'd0);
    check("rmf_level_async", 32'(o_level), 32'd0);
    check("rmf_ovf_async", 32'(o_overflow), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    any_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (o_tx == 1'b0 || o_busy == 1'b1) any_low = 1'b1;
    end
    check("rmf_line_stays_idle", 32'(any_low), 32'd0);
    check_idle("rmf_end");

    // Pointer wrap: 9 paced bytes
    for (int b = 0; b < 9; b++) begin
      i_data = wrap_bytes[b]; i_valid = 1'b1;
      @(negedge CLK); i_valid = 1'b0;
      @(negedge CLK);
      check_frame(wrap_bytes[b], 0);
      @(negedge CLK);
      check($sformatf("wrap_idle_%0d", b), 32'(o_busy), 32'd0);
    end
    check("wrap_ovf", 32'(o_overflow), 32'd0);
    check("wrap_level", 32'(o_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
